// File: rtl/simd_execution.sv
// simd_execution: NUM_PE independent signed multiply-accumulate lanes.
// Each lane multiplies its Kernel slice by its Input_Act slice every clock.
// A lane either restarts its window with the new product (first_data high)
// or adds the product to its running sum (first_data low).
// Result is taken straight from the accumulator registers.
// Optional build macro: SIMD_EXEC_SATURATE_EN. When it is defined, the
// accumulate addition clamps to the signed OUT_DATA_WIDTH range. When it is
// undefined, the addition wraps modulo 2^OUT_DATA_WIDTH. Loading a new window
// behaves the same in both builds.
module simd_execution #(
  parameter int NUM_PE         = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int OUT_DATA_WIDTH = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               first_data,
  input  logic [NUM_PE*DATA_WIDTH-1:0]       Kernel,
  input  logic [NUM_PE*DATA_WIDTH-1:0]       Input_Act,
  output logic [NUM_PE*OUT_DATA_WIDTH-1:0]   Result
);

  // Full-precision product width of two signed DATA_WIDTH operands.
  localparam int PW = 2 * DATA_WIDTH;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PE; gi++) begin : g_lane
      logic [DATA_WIDTH-1:0]     k_w;
      logic [DATA_WIDTH-1:0]     a_w;
      logic signed [PW-1:0]      k_ext;
      logic signed [PW-1:0]      a_ext;
      logic signed [PW-1:0]      prod;
      logic [OUT_DATA_WIDTH-1:0] prod_ext;
      logic [OUT_DATA_WIDTH-1:0] sum;
      logic [OUT_DATA_WIDTH-1:0] acc_d;
      logic [OUT_DATA_WIDTH-1:0] acc_q;

      assign k_w = Kernel[gi*DATA_WIDTH +: DATA_WIDTH];
      assign a_w = Input_Act[gi*DATA_WIDTH +: DATA_WIDTH];

      // Sign-extend both operands to the product width so the multiply is
      // done at full precision with no width mismatch.
      assign k_ext = $signed({{DATA_WIDTH{k_w[DATA_WIDTH-1]}}, k_w});
      assign a_ext = $signed({{DATA_WIDTH{a_w[DATA_WIDTH-1]}}, a_w});
      assign prod  = k_ext * a_ext;

      // Bring the product to the accumulator width, keeping its sign.
      if (OUT_DATA_WIDTH > PW) begin : g_sx
        assign prod_ext = {{(OUT_DATA_WIDTH-PW){prod[PW-1]}}, prod};
      end else begin : g_nx
        assign prod_ext = prod[OUT_DATA_WIDTH-1:0];
      end

      // Plain modular sum. The saturating build post-processes it below.
      assign sum = acc_q + prod_ext;

`ifdef SIMD_EXEC_SATURATE_EN
      logic                      ovf;
      logic [OUT_DATA_WIDTH-1:0] sat_val;
      // Signed overflow happens only when both addends share a sign and the
      // sum's sign differs from it. The clamp direction follows that shared
      // sign.
      assign ovf     = (acc_q[OUT_DATA_WIDTH-1] == prod_ext[OUT_DATA_WIDTH-1]) &&
                       (sum[OUT_DATA_WIDTH-1]   != acc_q[OUT_DATA_WIDTH-1]);
      assign sat_val = acc_q[OUT_DATA_WIDTH-1] ? {1'b1, {(OUT_DATA_WIDTH-1){1'b0}}}
                                               : {1'b0, {(OUT_DATA_WIDTH-1){1'b1}}};

      // Next accumulator value: restart the window, or add with clamping.
      always_comb begin
        acc_d = sum;
        if (ovf) begin
          acc_d = sat_val;
        end
        if (first_data) begin
          acc_d = prod_ext;
        end
      end
`else
      // Next accumulator value: restart the window, or add with wraparound.
      always_comb begin
        acc_d = sum;
        if (first_data) begin
          acc_d = prod_ext;
        end
      end
`endif

      // Accumulator register. Reset overrides the window control and data.
      always_ff @(posedge clk) begin
        if (reset) begin
          acc_q <= '0;
        end else begin
          acc_q <= acc_d;
        end
      end

      assign Result[gi*OUT_DATA_WIDTH +: OUT_DATA_WIDTH] = acc_q;
    end
  endgenerate

endmodule

// File: tb/tb_simd_execution.sv
// Directed testbench for simd_execution. It has two parts:
// - a table of per-cycle vectors for the default 16x8x32 configuration;
// - a hand-written overflow sequence on a narrow 2x8x16 instance, so that
//   wrap and saturation are reached in a few cycles.
module tb_simd_execution;

  localparam int NP  = 16;
  localparam int DW  = 8;
  localparam int OW  = 32;
  localparam int NP2 = 2;
  localparam int OW2 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               first_data;
  logic [NP*DW-1:0]   kernel;
  logic [NP*DW-1:0]   act;
  logic [NP*OW-1:0]   result;

  logic               first2;
  logic [NP2*DW-1:0]  kernel2;
  logic [NP2*DW-1:0]  act2;
  logic [NP2*OW2-1:0] result2;

  simd_execution #(.NUM_PE(NP), .DATA_WIDTH(DW), .OUT_DATA_WIDTH(OW)) dut (
    .clk(clk), .reset(reset), .first_data(first_data),
    .Kernel(kernel), .Input_Act(act), .Result(result)
  );

  simd_execution #(.NUM_PE(NP2), .DATA_WIDTH(DW), .OUT_DATA_WIDTH(OW2)) dut_narrow (
    .clk(clk), .reset(reset), .first_data(first2),
    .Kernel(kernel2), .Input_Act(act2), .Result(result2)
  );

  // One vector is one clock edge.
  // Lane 0 and lane 15 get individual operands.
  // Lanes 1..14 all get 'fill' as both kernel and activation.
  typedef struct {
    logic        rst;
    logic        first;
    logic [7:0]  k0, a0, k15, a15, fill;
    logic [31:0] e0, emid, e15;
  } vec_t;

  vec_t vecs[$];
  int   applied     = 0;
  int   miscompares = 0;

  function automatic vec_t mk(input logic rst, input logic first,
                              input int k0, input int a0, input int k15, input int a15,
                              input int fill, input int e0, input int emid, input int e15);
    vec_t v;
    v.rst = rst;    v.first = first;
    v.k0  = 8'(k0); v.a0  = 8'(a0);
    v.k15 = 8'(k15); v.a15 = 8'(a15);
    v.fill = 8'(fill);
    v.e0 = 32'(e0); v.emid = 32'(emid); v.e15 = 32'(e15);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare the narrow instance against expected lane values and log the edge.
  task automatic check2(input string name, input int exp0, input int exp1);
    logic [NP2*OW2-1:0] exp;
    exp = {16'(exp1), 16'(exp0)};
    applied++;
    if (result2 !== exp) begin
      miscompares++;
      $display("FAIL %s: got lane0=%0d lane1=%0d, required lane0=%0d lane1=%0d",
               name, $signed(result2[15:0]), $signed(result2[31:16]), exp0, exp1);
    end else begin
      $display("%s: lane0=%0d lane1=%0d", name, $signed(result2[15:0]), $signed(result2[31:16]));
    end
  endtask

  initial begin
    logic [NP*OW-1:0] exp;

    reset = 1'b1; first_data = 1'b0; kernel = '0; act = '0;
    first2 = 1'b0; kernel2 = '0; act2 = '0;

    // Reset held two edges with nonzero inputs on every lane.
    vecs.push_back(mk(1, 0, 3, 4, 5, 6, 9, 0, 0, 0));
    vecs.push_back(mk(1, 1, 3, 4, 5, 6, 9, 0, 0, 0));

    // 3x3 window: 2*3 accumulated nine times gives 54.
    for (int i = 1; i <= 9; i++) vecs.push_back(mk(0, i == 1, 2, 3, 0, 0, 0, 6*i, 0, 0));
    // Second window restarts at 1*1; the old sum is discarded.
    for (int i = 1; i <= 9; i++) vecs.push_back(mk(0, i == 1, 1, 1, 0, 0, 0, i, 0, 0));

    // Signed operands, lanes independent.
    // Lane 0: -128*127 per edge, ending at -146304. Lane 15: (-1)*(-1), ending at 9.
    for (int i = 1; i <= 9; i++)
      vecs.push_back(mk(0, i == 1, -128, 127, -1, -1, 0, -16256*i, 0, i));

    // Mid-window reset. Four edges of 10*10, then a reset edge, then two edges
    // of 1*1 with first_data low: the sum restarts from zero.
    for (int i = 1; i <= 4; i++) vecs.push_back(mk(0, i == 1, 10, 10, 0, 0, 0, 100*i, 0, 0));
    vecs.push_back(mk(1, 0, 10, 10, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 2, 0, 0));

    // first_data on every edge: each edge shows only its own product (-35).
    // Lanes 1..14 also restart each edge with 3*3 = 9.
    for (int i = 1; i <= 4; i++) vecs.push_back(mk(0, 1, 5, -7, -2, 4, 3, -35, 9, -8));

    // Most negative operands, loaded into a fresh window.
    vecs.push_back(mk(0, 1, -128, -128, 127, -128, 0, 16384, 0, -16256));

    for (int n = 0; n < vecs.size(); n++) begin
      reset      = vecs[n].rst;
      first_data = vecs[n].first;
      for (int l = 0; l < NP; l++) begin
        kernel[l*DW +: DW] = vecs[n].fill;
        act[l*DW +: DW]    = vecs[n].fill;
      end
      kernel[0 +: DW]        = vecs[n].k0;
      act[0 +: DW]           = vecs[n].a0;
      kernel[(NP-1)*DW +: DW] = vecs[n].k15;
      act[(NP-1)*DW +: DW]    = vecs[n].a15;
      tick();
      for (int l = 0; l < NP; l++) exp[l*OW +: OW] = vecs[n].emid;
      exp[0 +: OW]        = vecs[n].e0;
      exp[(NP-1)*OW +: OW] = vecs[n].e15;
      applied++;
      if (result !== exp) begin
        miscompares++;
        $display("FAIL vec%0d: got lane0=%0d lane1=%0d lane15=%0d, required lane0=%0d lane1=%0d lane15=%0d",
                 n, $signed(result[0 +: OW]), $signed(result[OW +: OW]), $signed(result[(NP-1)*OW +: OW]),
                 $signed(exp[0 +: OW]), $signed(exp[OW +: OW]), $signed(exp[(NP-1)*OW +: OW]));
      end else begin
        $display("vec%0d: lane0=%0d lane1=%0d lane15=%0d", n,
                 $signed(result[0 +: OW]), $signed(result[OW +: OW]), $signed(result[(NP-1)*OW +: OW]));
      end
    end

    // Overflow on the 16-bit accumulator instance.
    // Lane 0 adds 127*127 = 16129 per edge; lane 1 adds -128*127 = -16256.
    reset = 1'b0; first_data = 1'b0; kernel = '0; act = '0;
    kernel2 = {8'h80, 8'h7f};
    act2    = {8'h7f, 8'h7f};
    first2  = 1'b1;
    tick();
    check2("ovf_load", 16129, -16256);
    first2 = 1'b0;
    tick();
    check2("ovf_acc2", 32258, -32512);
`ifdef SIMD_EXEC_SATURATE_EN
    tick();
    check2("ovf_acc3", 32767, -32768);
    tick();
    check2("ovf_acc4", 32767, -32768);
`else
    tick();
    check2("ovf_acc3", -17149, 16768);
    tick();
    check2("ovf_acc4", -1020, 512);
`endif
    // A new window loads the bare product in both builds.
    kernel2 = {8'h05, 8'h05};
    act2    = {8'hf9, 8'hf9};
    first2  = 1'b1;
    tick();
    check2("ovf_reload", -35, -35);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
